// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose : bundles the control unit's decode inputs and datapath control outputs.
// Ports   : master = control unit (consumes op/funct/zero[/memready], drives controls),
//           slave = datapath side. memready exists only when MC_MEMWAIT_EN is defined.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
`ifdef MC_MEMWAIT_EN
  logic       memready;
`endif
  logic       pcen;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       immzext;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic       illegal;

  modport master (
`ifdef MC_MEMWAIT_EN
    input  memready,
`endif
    input  op, funct, zero,
    output pcen, iord, irwrite, memwrite, regwrite, memtoreg, regdst,
           alusrca, alusrcb, immzext, pcsrc, alucontrol, illegal
  );

  modport slave (
`ifdef MC_MEMWAIT_EN
    output memready,
`endif
    output op, funct, zero,
    input  pcen, iord, irwrite, memwrite, regwrite, memtoreg, regdst,
           alusrca, alusrcb, immzext, pcsrc, alucontrol, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Purpose : multicycle MIPS32 control FSM; sequences ALU, register file and unified memory
//           over 2-5 cycles per instruction and flags unsupported op/funct (sticky).
// Ports   : clk, reset (async, active-high), bus (master modport: op/funct/zero in, controls out).
//           Optional MC_MEMWAIT_EN: memready stalls FETCH/MEMRD/MEMWR until the access completes.
module mips_multicycle_ctrl (
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_ctrl_if.master        bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
    RTYPEWB, BRANCH, IMMEX, IMMWB, JUMP, JR
  } state_t;

  state_t     state, next;
  logic       illegal_q;
  logic       mem_ok;
  logic       r_ok;
  logic [3:0] r_alu;
  logic       dec_illegal;
  logic       pcwrite, branch;
  logic       iord, irwrite, memwrite, regwrite, memtoreg, regdst, alusrca, immzext;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;

`ifdef MC_MEMWAIT_EN
  assign mem_ok = bus.memready;
`else
  assign mem_ok = 1'b1;
`endif

  // R-type funct decode: legality and ALU operation
  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (bus.funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      6'b000000: r_alu = ALU_SLL;
      6'b000010: r_alu = ALU_SRL;
      FN_JR:     r_alu = ALU_ADD;
      default:   r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_R:                       dec_illegal = ~r_ok;
      OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_J: dec_illegal = 1'b0;
      default:                    dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                illegal_q <= 1'b0;
    else if (state == DECODE && dec_illegal)  illegal_q <= 1'b1;
  end

  always_comb begin
    next       = FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    immzext    = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ok;
        pcwrite = mem_ok;
        next    = mem_ok ? DECODE : FETCH;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while decoding
        alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW:             next = MEMADR;
          OP_R:                     next = !r_ok ? FETCH : (bus.funct == FN_JR) ? JR : RTYPEEX;
          OP_BEQ, OP_BNE:           next = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: next = IMMEX;
          OP_J:                     next = JUMP;
          default:                  next = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        next    = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        next = mem_ok ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        // Strobe held through the wait so the memory sees a stable request
        iord     = 1'b1;
        memwrite = 1'b1;
        next     = mem_ok ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = r_alu;
        next       = RTYPEWB;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        immzext    = (bus.op == OP_ANDI) || (bus.op == OP_ORI);
        alucontrol = (bus.op == OP_ANDI) ? ALU_AND : (bus.op == OP_ORI) ? ALU_OR : ALU_ADD;
        next       = IMMWB;
      end
      IMMWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      JR: begin
        alusrca = 1'b1;
        pcsrc   = 2'b11;
        pcwrite = 1'b1;
      end
      default: alucontrol = 4'b0000;  // unreachable encodings: everything off, recover to FETCH
    endcase
  end

  // beq takes the branch on zero, bne on not-zero
  assign bus.pcen       = pcwrite | (branch & (bus.zero ^ (bus.op == OP_BNE)));
  assign bus.iord       = iord;
  assign bus.irwrite    = irwrite;
  assign bus.memwrite   = memwrite;
  assign bus.regwrite   = regwrite;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.immzext    = immzext;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.illegal    = illegal_q;

endmodule
